// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART: register offsets, STATUS/CTRL bit positions
// and the 2-bit encoding used by both the TX and RX state machines.
package uart_pkg;

    localparam logic [7:0] UART_DATA   = 8'h00;
    localparam logic [7:0] UART_DIV    = 8'h04;
    localparam logic [7:0] UART_STATUS = 8'h08;
    localparam logic [7:0] UART_CTRL   = 8'h0C;

    localparam int unsigned STAT_TX_BUSY      = 0;
    localparam int unsigned STAT_TX_FULL      = 1;
    localparam int unsigned STAT_RX_VALID     = 2;
    localparam int unsigned STAT_RX_OVERRUN   = 3;
    localparam int unsigned STAT_RX_FRAME_ERR = 4;

    localparam int unsigned CTRL_RX_IRQ_EN = 0;
    localparam int unsigned CTRL_CLR_ERR   = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power of two.
// A pop of a full FIFO frees the slot for a push on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_fifo.sv
// Memory-mapped full-duplex UART with TX/RX FIFOs, sticky error flags and a level irq.
// Bit period is DIV+1 clocks; each FSM reloads its own down-counter from DIV.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] DIV_RESET  = 32'd1
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        wen,
    input  logic        ren,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);

    logic [7:0]  reg_addr;
    logic        wr_data, wr_div, wr_ctrl, rd_data;
    logic        unused_addr;

    logic [31:0] div_q, div_d;
    logic        rx_irq_en_q, rx_irq_en_d;
    logic        overrun_q, overrun_d;
    logic        frame_err_q, frame_err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;
    logic [31:0] status;

    logic [1:0]  tx_state_q, tx_state_d;
    logic [31:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d;
    logic        tx_pop, tx_full, tx_empty;
    logic [7:0]  tx_dout;

    logic        rx_sync1_q, rx_sync2_q, rx_prev_q;
    logic [1:0]  rx_state_q, rx_state_d;
    logic [31:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_push, rx_pop, rx_full, rx_empty, rx_frame_evt, rx_overrun_evt;
    logic [7:0]  rx_dout;

    assign reg_addr    = addr[7:0];
    assign unused_addr = ^addr[31:8];
    assign wr_data     = wen && (reg_addr == UART_DATA);
    assign wr_div      = wen && (reg_addr == UART_DIV);
    assign wr_ctrl     = wen && (reg_addr == UART_CTRL);
    assign rd_data     = ren && (reg_addr == UART_DATA);
    assign rx_pop      = rd_data & ~rx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (wr_data),
        .pop   (tx_pop),
        .din   (wdata[7:0]),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_shift_q),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // TX: the serial output is registered, so it trails the state by one clock.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_dout;
                    tx_cnt_d   = div_q;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d   = div_q;
                    tx_bit_d   = 3'd0;
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q - 32'd1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d   = div_q;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q - 32'd1;
                end
            end
            default: begin
                if (tx_cnt_q == '0) begin
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_dout;
                        tx_cnt_d   = div_q;
                        tx_state_d = ST_START;
                    end else begin
                        tx_state_d = ST_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 32'd1;
                end
            end
        endcase
        case (tx_state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = tx_shift_q[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // RX: START waits half a bit so every later sample lands mid-bit.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_push      = 1'b0;
        rx_frame_evt = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_sync2_q) begin
                    rx_cnt_d   = {1'b0, div_q[31:1]};
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt_q == '0) begin
                    if (rx_sync2_q) begin
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_cnt_d   = div_q;
                        rx_bit_d   = 3'd0;
                        rx_state_d = ST_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 32'd1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_cnt_d   = div_q;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q - 32'd1;
                end
            end
            default: begin
                if (rx_cnt_q == '0) begin
                    rx_push      = rx_sync2_q;
                    rx_frame_evt = ~rx_sync2_q;
                    rx_state_d   = ST_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q - 32'd1;
                end
            end
        endcase
    end

    assign rx_overrun_evt = rx_push & rx_full & ~rx_pop;

    always_comb begin
        status                    = '0;
        status[STAT_TX_BUSY]      = ~tx_empty | (tx_state_q != ST_IDLE);
        status[STAT_TX_FULL]      = tx_full;
        status[STAT_RX_VALID]     = ~rx_empty;
        status[STAT_RX_OVERRUN]   = overrun_q;
        status[STAT_RX_FRAME_ERR] = frame_err_q;

        div_d       = wr_div ? wdata : div_q;
        rx_irq_en_d = wr_ctrl ? wdata[CTRL_RX_IRQ_EN] : rx_irq_en_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (wr_ctrl && wdata[CTRL_CLR_ERR]) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        // A line event in the same cycle as a clear is not lost.
        if (rx_overrun_evt) overrun_d = 1'b1;
        if (rx_frame_evt)   frame_err_d = 1'b1;

        irq_d   = rx_irq_en_q & ~rx_empty;
        rdata_d = rdata_q;
        if (ren) begin
            case (reg_addr)
                UART_DATA:   rdata_d = rx_empty ? 32'd0 : {24'd0, rx_dout};
                UART_DIV:    rdata_d = div_q;
                UART_STATUS: rdata_d = status;
                UART_CTRL:   rdata_d = {31'd0, rx_irq_en_q};
                default:     rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            div_q       <= DIV_RESET;
            rx_irq_en_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
            tx_state_q  <= ST_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_q        <= 1'b1;
            rx_sync1_q  <= 1'b1;
            rx_sync2_q  <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= ST_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
        end else begin
            div_q       <= div_d;
            rx_irq_en_q <= rx_irq_en_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            rx_sync1_q  <= rx;
            rx_sync2_q  <= rx_sync1_q;
            rx_prev_q   <= rx_sync2_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
        end
    end

    assign rdata = rdata_q;
    assign tx    = tx_q;
    assign irq   = irq_q;

endmodule
